// File: rtl/hamming_scrub_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// hamming_ctrl_pkg
// Shared types and constants for the Hamming scrub scheduler.
//   state_e      : scheduler FSM state encoding (visible on the state output)
//   ERR_COUNT_W  : width of the saturating corrected-window counter
//   max_int()    : elaboration-time helper for sizing shared counters
// -----------------------------------------------------------------------------
package hamming_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        CHECK    = 2'd2,
        WAIT_FIX = 2'd3
    } state_e;

    localparam int ERR_COUNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hamming_scrub_scheduler_if.sv
// -----------------------------------------------------------------------------
// hamming_scrub_scheduler_if
// Bundles the scheduler's request inputs and status outputs.
//   master : requester / host side (drives inc_req, scrub_req, err_detected)
//   slave  : scheduler side (drives cnt_enable and all status outputs)
// Signals:
//   inc_req      requester wants one counter increment this cycle
//   scrub_req    host forces a check window (level)
//   err_detected datapath mismatch flag
//   cnt_enable   registered enable to the protected counter datapath
//   state        current FSM state
//   pending      increments deferred during check windows
//   overflow     sticky: an increment was lost at pending saturation
//   err_count    saturating count of windows that needed correction
//   fix_fault    sticky: a correction did not clear in time
//   window_done  one-cycle pulse when a check window closes
// -----------------------------------------------------------------------------
interface hamming_scrub_scheduler_if #(
    parameter int PEND_W = 4
);
    import hamming_ctrl_pkg::*;

    logic                   inc_req;
    logic                   scrub_req;
    logic                   err_detected;
    logic                   cnt_enable;
    state_e                 state;
    logic [PEND_W-1:0]      pending;
    logic                   overflow;
    logic [ERR_COUNT_W-1:0] err_count;
    logic                   fix_fault;
    logic                   window_done;

    modport master (
        output inc_req, scrub_req, err_detected,
        input  cnt_enable, state, pending, overflow, err_count, fix_fault,
               window_done
    );

    modport slave (
        input  inc_req, scrub_req, err_detected,
        output cnt_enable, state, pending, overflow, err_count, fix_fault,
               window_done
    );

endinterface

// File: rtl/hamming_scrub_scheduler_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up/down counter that saturates at both ends instead of wrapping.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears count
//   inc   : add one (held at all-ones)
//   dec   : subtract one (held at zero)
//   count : current value; inc and dec together leave it unchanged
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; combinational blocks use blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec && (count != MAX)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hamming_scrub_scheduler.sv
// -----------------------------------------------------------------------------
// hamming_scrub_scheduler
// Gates increments to a Hamming-protected counter so that the datapath is
// periodically quiesced for a check window. Increments requested while the
// datapath is held off are deferred in a saturating pending counter and
// replayed once the window closes.
// Parameters:
//   SCRUB_PERIOD : increments issued between forced check windows
//   CHECK_CYCLES : cnt_enable low time of each check window
//   FIX_TIMEOUT  : maximum cycles spent waiting for a correction
//   PEND_W       : pending-increment counter width
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of hamming_scrub_scheduler_if (requests in, status out)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module hamming_scrub_scheduler
    import hamming_ctrl_pkg::*;
#(
    parameter int SCRUB_PERIOD = 64,
    parameter int CHECK_CYCLES = 3,
    parameter int FIX_TIMEOUT  = 16,
    parameter int PEND_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    hamming_scrub_scheduler_if.slave bus
);

    localparam int PERIOD_W = $clog2(SCRUB_PERIOD + 1);
    // One counter times both the CHECK window and the WAIT_FIX timeout.
    localparam int WIN_W    = $clog2(max_int(CHECK_CYCLES, FIX_TIMEOUT) + 1);

    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SCRUB_PERIOD - 1);
    localparam logic [WIN_W-1:0]    CHECK_LAST  = WIN_W'(CHECK_CYCLES - 1);
    localparam logic [WIN_W-1:0]    FIX_LAST    = WIN_W'(FIX_TIMEOUT - 1);
    localparam logic [PEND_W-1:0]   PEND_MAX    = '1;

    logic inc_req;
    logic scrub_req;
    logic err_detected;

    assign inc_req      = bus.inc_req;
    assign scrub_req    = bus.scrub_req;
    assign err_detected = bus.err_detected;

    state_e                 state_q,    state_d;
    logic                   cnt_en_q,   cnt_en_d;
    logic [PERIOD_W-1:0]    period_q,   period_d;
    logic [WIN_W-1:0]       win_q,      win_d;
    logic                   done_q,     done_d;
    logic                   fault_q,    fault_d;
    logic                   overflow_q, overflow_d;

    logic [PEND_W-1:0]      pending;
    logic [ERR_COUNT_W-1:0] err_count;

    logic pend_inc;
    logic pend_dec;
    logic err_inc;
    logic serve;
    logic period_hit;
    logic pend_nz;
    logic pend_full;

    assign pend_nz   = (pending != '0);
    assign pend_full = (pending == PEND_MAX);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_en_d   = 1'b0;
        period_d   = period_q;
        win_d      = win_q;
        done_d     = 1'b0;
        fault_d    = fault_q;
        pend_inc   = 1'b0;
        pend_dec   = 1'b0;
        err_inc    = 1'b0;
        serve      = 1'b0;
        period_hit = cnt_en_q && (period_q == PERIOD_LAST);

        case (state_q)
            IDLE: begin
                state_d = RUN;
                serve   = 1'b1;
            end

            RUN: begin
                if (cnt_en_q) begin
                    period_d = period_hit ? '0 : period_q + 1'b1;
                end
                if (scrub_req || period_hit) begin
                    // The request seen on the entry edge cannot be issued any
                    // more, so it is deferred like any in-window request.
                    state_d  = CHECK;
                    period_d = '0;
                    win_d    = '0;
                    pend_inc = inc_req;
                end else begin
                    serve = 1'b1;
                end
            end

            CHECK: begin
                pend_inc = inc_req;
                if (win_q == CHECK_LAST) begin
                    win_d = '0;
                    if (err_detected) begin
                        state_d = WAIT_FIX;
                        err_inc = 1'b1;
                    end else begin
                        state_d = RUN;
                        done_d  = 1'b1;
                        serve   = 1'b1;
                    end
                end else begin
                    win_d = win_q + 1'b1;
                end
            end

            WAIT_FIX: begin
                pend_inc = inc_req;
                if (!err_detected || (win_q == FIX_LAST)) begin
                    state_d = RUN;
                    win_d   = '0;
                    done_d  = 1'b1;
                    serve   = 1'b1;
                    fault_d = fault_q | err_detected;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Whenever the next cycle is a RUN cycle, issue one increment if any
        // is wanted. A backlog is served oldest-first: a new request replaces
        // the one drained, so pending only falls when inc_req is idle.
        if (serve) begin
            cnt_en_d = inc_req | pend_nz;
            pend_inc = inc_req & pend_nz;
            pend_dec = pend_nz;
        end

        overflow_d = overflow_q | (pend_inc & ~pend_dec & pend_full);
    end

    // -------------------------------------------------------------------------
    // Registered datapath and status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_en_q   <= 1'b0;
            period_q   <= '0;
            win_q      <= '0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cnt_en_q   <= cnt_en_d;
            period_q   <= period_d;
            win_q      <= win_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            overflow_q <= overflow_d;
        end
    end

    sat_counter #(
        .WIDTH (PEND_W)
    ) u_pending (
        .clk   (clk),
        .rst   (rst),
        .inc   (pend_inc),
        .dec   (pend_dec),
        .count (pending)
    );

    sat_counter #(
        .WIDTH (ERR_COUNT_W)
    ) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .dec   (1'b0),
        .count (err_count)
    );

    assign bus.cnt_enable  = cnt_en_q;
    assign bus.state       = state_q;
    assign bus.pending     = pending;
    assign bus.overflow    = overflow_q;
    assign bus.err_count   = err_count;
    assign bus.fix_fault   = fault_q;
    assign bus.window_done = done_q;

endmodule

// File: tb/tb_hamming_scrub_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hamming_scrub_scheduler
// Directed bench for hamming_scrub_scheduler. A default instance covers the
// period window, scrub windows, correction wait, timeout and reset; a second
// instance with a 2-bit pending counter and 6-cycle window covers saturation.
// Inputs change and outputs are observed 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_hamming_scrub_scheduler;
    import hamming_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    int   en_cnt;
    int   en_before;
    int   chk_cnt;
    int   done_cnt;
    int   wf_cnt;
    logic seen_check;
    logic en_in_check;

    always #5 clk = ~clk;

    hamming_scrub_scheduler_if #(.PEND_W(4)) bus ();
    hamming_scrub_scheduler_if #(.PEND_W(2)) bus_small ();

    hamming_scrub_scheduler #(
        .SCRUB_PERIOD (64),
        .CHECK_CYCLES (3),
        .FIX_TIMEOUT  (16),
        .PEND_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    hamming_scrub_scheduler #(
        .SCRUB_PERIOD (64),
        .CHECK_CYCLES (6),
        .FIX_TIMEOUT  (16),
        .PEND_W       (2)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_small)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst                    = 1'b1;
        bus.inc_req            = 1'b0;
        bus.scrub_req          = 1'b0;
        bus.err_detected       = 1'b0;
        bus_small.inc_req      = 1'b0;
        bus_small.scrub_req    = 1'b0;
        bus_small.err_detected = 1'b0;
        #1;

        // ---- reset state ----
        check("rst_state",       bus.state,       IDLE);
        check("rst_cnt_enable",  bus.cnt_enable,  0);
        check("rst_pending",     bus.pending,     0);
        check("rst_overflow",    bus.overflow,    0);
        check("rst_err_count",   bus.err_count,   0);
        check("rst_fix_fault",   bus.fix_fault,   0);
        check("rst_window_done", bus.window_done, 0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        check("idle_after_release", bus.state, IDLE);
        tick();
        check("run_after_idle", bus.state,      RUN);
        check("run_first_en",   bus.cnt_enable, 0);

        // ---- inc_req held 70 cycles across a period-triggered window ----
        bus.inc_req = 1'b1;
        en_cnt      = 0;
        en_before   = 0;
        chk_cnt     = 0;
        done_cnt    = 0;
        seen_check  = 1'b0;
        en_in_check = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (bus.state == CHECK) begin
                chk_cnt++;
                seen_check = 1'b1;
                if (bus.cnt_enable) en_in_check = 1'b1;
            end
            if (bus.cnt_enable) begin
                en_cnt++;
                if (!seen_check) en_before++;
            end
            if (bus.window_done) done_cnt++;
        end
        check("period_en_before_check", en_before,   64);
        check("period_check_cycles",    chk_cnt,     3);
        check("period_en_in_check",     en_in_check, 0);
        check("period_window_done",     done_cnt,    1);
        check("period_pending_held",    bus.pending, 3);
        check("period_state_run",       bus.state,   RUN);
        bus.inc_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cnt_enable) en_cnt++;
        end
        check("period_total_en",     en_cnt,         70);
        check("period_pending_zero", bus.pending,    0);
        check("period_en_idle",      bus.cnt_enable, 0);

        // ---- scrub_req pulse, clean window ----
        bus.scrub_req = 1'b1;
        tick();
        bus.scrub_req = 1'b0;
        check("scrub_check_1", bus.state, CHECK);
        tick();
        check("scrub_check_2", bus.state, CHECK);
        tick();
        check("scrub_check_3",    bus.state,      CHECK);
        check("scrub_check_3_en", bus.cnt_enable, 0);
        tick();
        check("scrub_back_run", bus.state,       RUN);
        check("scrub_done",     bus.window_done, 1);
        tick();
        check("scrub_done_pulse", bus.window_done, 0);
        check("scrub_err_count",  bus.err_count,   0);

        // ---- error at window close, cleared two cycles later ----
        bus.scrub_req = 1'b1;
        tick();
        bus.scrub_req    = 1'b0;
        bus.err_detected = 1'b1;
        tick();
        tick();
        check("fix_check_3", bus.state, CHECK);
        tick();
        check("fix_wait_1",     bus.state,       WAIT_FIX);
        check("fix_err_count",  bus.err_count,   1);
        check("fix_wait_en",    bus.cnt_enable,  0);
        check("fix_wait_done",  bus.window_done, 0);
        tick();
        check("fix_wait_2", bus.state, WAIT_FIX);
        bus.err_detected = 1'b0;
        tick();
        check("fix_back_run", bus.state,       RUN);
        check("fix_done",     bus.window_done, 1);
        check("fix_no_fault", bus.fix_fault,   0);
        tick();
        check("fix_done_pulse", bus.window_done, 0);

        // ---- err_detected stuck: timeout ----
        bus.scrub_req = 1'b1;
        tick();
        bus.scrub_req    = 1'b0;
        bus.err_detected = 1'b1;
        tick();
        tick();
        tick();
        check("tmo_fault_not_yet", bus.fix_fault, 0);
        wf_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.state != WAIT_FIX) break;
            wf_cnt++;
            tick();
        end
        check("tmo_wait_cycles", wf_cnt,          16);
        check("tmo_state_run",   bus.state,       RUN);
        check("tmo_fix_fault",   bus.fix_fault,   1);
        check("tmo_done",        bus.window_done, 1);
        check("tmo_err_count",   bus.err_count,   2);
        tick();
        check("tmo_stay_run", bus.state, RUN);
        bus.err_detected = 1'b0;

        // ---- held scrub_req: ignored in window, re-triggers on first RUN ----
        bus.scrub_req = 1'b1;
        tick();
        tick();
        tick();
        check("held_check_3", bus.state, CHECK);
        tick();
        check("held_run",  bus.state,       RUN);
        check("held_done", bus.window_done, 1);
        tick();
        check("held_retrigger", bus.state, CHECK);
        bus.scrub_req = 1'b0;
        tick();
        tick();
        tick();
        check("held_final_run", bus.state, RUN);

        // ---- PEND_W=2 saturation through a 6-cycle window ----
        bus_small.scrub_req = 1'b1;
        bus_small.inc_req   = 1'b1;
        tick();
        bus_small.scrub_req = 1'b0;
        check("sat_check_1",   bus_small.state,   CHECK);
        check("sat_pending_1", bus_small.pending, 1);
        tick();
        tick();
        check("sat_pending_3",  bus_small.pending,  3);
        check("sat_no_ovf_yet", bus_small.overflow, 0);
        tick();
        tick();
        tick();
        check("sat_check_6",  bus_small.state,    CHECK);
        check("sat_pending",  bus_small.pending,  3);
        check("sat_overflow", bus_small.overflow, 1);
        tick();
        check("sat_done", bus_small.window_done, 1);
        bus_small.inc_req = 1'b0;
        en_cnt = bus_small.cnt_enable ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_small.cnt_enable) en_cnt++;
        end
        check("sat_drain_en",      en_cnt,             4);
        check("sat_drain_pending", bus_small.pending,  0);
        check("sat_ovf_sticky",    bus_small.overflow, 1);

        // ---- reset in the middle of a window ----
        bus.scrub_req = 1'b1;
        bus.inc_req   = 1'b1;
        tick();
        bus.scrub_req = 1'b0;
        tick();
        bus.inc_req = 1'b0;
        check("mid_state_check", bus.state,   CHECK);
        check("mid_pending",     bus.pending, 2);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_state",       bus.state,          IDLE);
        check("mid_rst_cnt_enable",  bus.cnt_enable,     0);
        check("mid_rst_pending",     bus.pending,        0);
        check("mid_rst_err_count",   bus.err_count,      0);
        check("mid_rst_fix_fault",   bus.fix_fault,      0);
        check("mid_rst_window_done", bus.window_done,    0);
        check("mid_rst_small_ovf",   bus_small.overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rel_idle", bus.state, IDLE);
        tick();
        check("mid_rel_run", bus.state, RUN);
        done_cnt = bus.window_done ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.window_done) done_cnt++;
        end
        check("mid_no_done",      done_cnt,    0);
        check("mid_pending_gone", bus.pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_scrub_scheduler.md
HAMMING_SCRUB_SCHEDULER -- requirements
Module: hamming_scrub_scheduler

Interface
REQ-001 Parameter SCRUB_PERIOD, default 64: increments issued between forced check windows.
REQ-002 Parameter CHECK_CYCLES, default 3: minimum low time of cnt_enable per check window.
REQ-003 Parameter FIX_TIMEOUT, default 16: maximum cycles spent waiting for a correction.
REQ-004 Parameter PEND_W, default 4: pending-increment counter width.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 inc_req  in  1  requester wants one counter increment this cycle.
REQ-008 scrub_req  in  1  host forces a check window; level, sampled each cycle.
REQ-009 err_detected  in  1  datapath mismatch flag (busy and count differs from stored copy).
REQ-010 cnt_enable  out  1  registered enable to the protected counter datapath.
REQ-011 state  out  2  current FSM state encoding.
REQ-012 pending  out  PEND_W  increments deferred during check windows.
REQ-013 overflow  out  1  sticky: an inc_req was lost because pending was saturated.
REQ-014 err_count  out  8  saturating count of windows that needed correction.
REQ-015 fix_fault  out  1  sticky: correction did not clear within FIX_TIMEOUT.
REQ-016 window_done  out  1  one-cycle pulse when a check window closes.

Function
REQ-017 FSM states SHALL be IDLE=0, RUN=1, CHECK=2, WAIT_FIX=3.
REQ-018 IDLE: cnt_enable=0 for exactly one cycle after reset release, then RUN unconditionally.
REQ-019 RUN: next cnt_enable = inc_req | (pending!=0); each cycle with cnt_enable=1 increments period counter.
REQ-020 RUN: pending decrements when pending!=0 and inc_req=0; unchanged when both present.
REQ-021 RUN -> CHECK when period counter reaches SCRUB_PERIOD-1 with an increment issued, or scrub_req=1; period counter clears on entry.
REQ-022 CHECK: cnt_enable=0 for CHECK_CYCLES cycles, counted from the first low cycle.
REQ-023 CHECK/WAIT_FIX: inc_req increments pending, saturating at 2^PEND_W-1; an inc_req at saturation sets overflow.
REQ-024 End of CHECK: err_detected=0 -> RUN with window_done pulse; err_detected=1 -> WAIT_FIX and err_count++ (saturate at 255).
REQ-025 WAIT_FIX: cnt_enable held 0; exits to RUN with window_done when err_detected=0.
REQ-026 WAIT_FIX exceeding FIX_TIMEOUT cycles SHALL set fix_fault and go to RUN with window_done.
REQ-027 scrub_req in CHECK/WAIT_FIX SHALL be ignored; held scrub_req re-triggers CHECK on the first RUN cycle.
REQ-028 cnt_enable SHALL never be high in CHECK, WAIT_FIX or IDLE; latency inc_req -> cnt_enable is one cycle in RUN.
REQ-029 Increments are conserved: every accepted inc_req yields exactly one cnt_enable cycle, except those flagged by overflow.

Reset
REQ-030 rst asserted: state=IDLE, cnt_enable=0, pending=0, period counter=0, overflow=0, err_count=0, fix_fault=0, window_done=0, immediately.
REQ-031 rst mid-window SHALL discard pending increments and the in-progress window without a window_done pulse.

Structure
REQ-032 State enum and state encodings SHALL live in package hamming_ctrl_pkg.
REQ-033 Saturating counters (pending, err_count) SHALL use one sub-module sat_counter, parameterised by width, with inc/dec inputs.
REQ-034 All outputs registered; no combinational path from inputs to outputs.

Verification
REQ-035 inc_req held 1 for 70 cycles, SCRUB_PERIOD=64 -> 64 cnt_enable cycles, 3 low cycles, pending=3 then drains to 0 after inc_req drops.
REQ-036 scrub_req pulse in RUN, err_detected=0 -> CHECK for 3 cycles, window_done at close, err_count=0.
REQ-037 err_detected=1 at end of CHECK, dropped 2 cycles later -> WAIT_FIX 2 cycles, err_count=1, window_done once.
REQ-038 err_detected stuck 1 -> fix_fault=1 after 16 WAIT_FIX cycles, return to RUN.
REQ-039 PEND_W=2, inc_req held through a 6-cycle window -> pending=3, overflow=1.
REQ-040 rst asserted during CHECK with pending=2 -> all outputs to reset values that same cycle, IDLE then RUN after release.
